// File: rtl/score_display_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : score_display_mux                                               |
// | Desc   : Binary score -> BCD (sequential double-dabble, one bit/cycle),  |
// |          atomically latched and time-multiplexed onto NUM_DIGITS         |
// |          common-anode 7-segment digits.                                  |
// | Config : define SEG_LZB_EN to blank leading zero digits.                 |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module score_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_W       = 15,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  segclk,
  input  logic                  clr,
  input  logic [BIN_W-1:0]      score,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  sat
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Largest value the display can show: 10^NUM_DIGITS - 1.
  function automatic logic [63:0] max_value(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_value(NUM_DIGITS);

  // Active-low {g,f,e,d,c,b,a}; out-of-range nibbles go dark.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 busy_q, busy_d;
  logic                 sat_q, sat_d;
  logic [BCD_W-1:0]     disp_q, disp_d;
  logic [REF_W-1:0]     ref_q, ref_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic [BCD_W-1:0]     bcd_adj;
  logic [3:0]           cur_nib;

  // Converter FSM: sample/saturate, shift BIN_W bits through the BCD accumulator, commit.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    sat_d   = sat_q;
    disp_d  = disp_q;
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (64'(score) > MAX_VAL) begin
          bin_d  = MAX_VAL[BIN_W-1:0];
          pend_d = 1'b1;
        end else begin
          bin_d  = score;
          pend_d = 1'b0;
        end
        bcd_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        // Display regs change only here, so the scan never sees a half-built value.
        disp_d  = bcd_q;
        sat_d   = pend_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan: refresh divider, digit index, and the registered an/seg pair for that index.
  always_comb begin
    ref_d   = ref_q + 1'b1;
    idx_d   = idx_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    an_d    = ~(NUM_DIGITS'(1) << idx_q);
    cur_nib = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SEG_LZB_EN
    // Blank when this digit and everything above it is zero; digit 0 always shows.
    if ((idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0)) seg_d = 7'b1111111;
    else seg_d = decode(cur_nib);
`else
    seg_d = decode(cur_nib);
`endif
  end

  // State register for converter and scan; clr aborts everything immediately.
  always_ff @(posedge segclk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
      disp_q  <= '0;
      ref_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'b1111111;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      sat_q   <= sat_d;
      disp_q  <= disp_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;
  assign sat  = sat_q;

endmodule
`default_nettype wire
